// File: rtl/bram_stream_buffer.sv
// bram_stream_buffer
// Capture/replay buffer for the AXI-Stream path between the MM2S async FIFO
// and the next processing stage. A write command captures up to 2^ADDR_W
// beats into inferred block RAM. A read command replays the stored frame
// downstream, either once or looped.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   bram_en / bram_opts      command strobe and opcode (00 reset, 01 write,
//                            10 read, 11 stop)
//   bram_depth               requested write depth (0 or >2^ADDR_W = full)
//   bram_loop                replay mode, sampled with the read command
//   bram_status              00 RST, 01 WAITING, 10 WRITING, 11 READING
//   stored_count             beats currently held
//   loop_cnt                 completed replay passes (saturating)
//   s_axis_afifo_*           capture stream in
//   m_axis_bram_array_*      replay stream out
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RST  | contents discarded, counters cleared; always moves to WAIT
// ST_WAIT | idle, accepts write/read commands
// ST_WRITE| capturing beats until depth reached, tlast, stop or reset
// ST_READ | replaying stored frame, once or looped
module bram_stream_buffer #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [1:0]        bram_status,
    input  logic              bram_en,
    input  logic [1:0]        bram_opts,
    input  logic [ADDR_W:0]   bram_depth,
    input  logic              bram_loop,
    output logic [ADDR_W:0]   stored_count,
    output logic [CNT_W-1:0]  loop_cnt,
    input  logic [DATA_W-1:0] s_axis_afifo_tdata,
    input  logic              s_axis_afifo_tvalid,
    output logic              s_axis_afifo_tready,
    input  logic              s_axis_afifo_tlast,
    output logic [DATA_W-1:0] m_axis_bram_array_tdata,
    output logic              m_axis_bram_array_tvalid,
    input  logic              m_axis_bram_array_tready,
    output logic              m_axis_bram_array_tlast
);

    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_WRITE = 2'b10,
        ST_READ  = 2'b11
    } state_t;

    localparam logic [ADDR_W:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  ONE      = (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem_q;

    logic [ADDR_W:0]   depth, wr_ptr, rd_addr;
    logic              loop_mode, issue_done;
    logic              inflight, inflight_last;
    logic              out_valid, out_last, sk_valid, sk_last;
    logic [DATA_W-1:0] out_data, sk_data;

    logic cmd_reset, cmd_write, cmd_read, cmd_stop;
    logic wr_fire, wr_end, rd_pop, rd_issue, rd_is_last, rd_flush;
    logic [1:0] occupancy;

    always_comb begin
        cmd_reset  = bram_en && (bram_opts == 2'b00);
        cmd_write  = bram_en && (bram_opts == 2'b01) && (state == ST_WAIT);
        cmd_read   = bram_en && (bram_opts == 2'b10) && (state == ST_WAIT)
                     && (stored_count != '0);
        cmd_stop   = bram_en && (bram_opts == 2'b11)
                     && ((state == ST_WRITE) || (state == ST_READ));

        s_axis_afifo_tready = (state == ST_WRITE) && (wr_ptr < depth);
        wr_fire    = s_axis_afifo_tready && s_axis_afifo_tvalid && !cmd_reset && !rst;
        wr_end     = wr_fire && (s_axis_afifo_tlast || (wr_ptr == depth - ONE));

        rd_pop     = out_valid && m_axis_bram_array_tready;
        // Entries already committed: output reg, skid reg, and the RAM read in flight.
        // A new read is issued only if it is guaranteed a slot, so the skid never overflows.
        occupancy  = {1'b0, out_valid} + {1'b0, sk_valid} + {1'b0, inflight};
        rd_is_last = (rd_addr == stored_count - ONE);
        rd_issue   = (state == ST_READ) && !issue_done && ((occupancy != 2'd2) || rd_pop);

        bram_status              = state;
        m_axis_bram_array_tdata  = out_data;
        m_axis_bram_array_tvalid = out_valid;
        m_axis_bram_array_tlast  = out_valid && out_last;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:   state_next = ST_WAIT;
            ST_WAIT: begin
                if (cmd_write)     state_next = ST_WRITE;
                else if (cmd_read) state_next = ST_READ;
            end
            ST_WRITE: if (cmd_stop || wr_end) state_next = ST_WAIT;
            ST_READ:  if (cmd_stop || (rd_pop && out_last && !loop_mode)) state_next = ST_WAIT;
        endcase
        if (cmd_reset) state_next = ST_RST;
        rd_flush = (state_next != ST_READ);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RST;
        else     state <= state_next;
    end

    // RAM array and read register kept reset-free so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire)  mem[wr_ptr[ADDR_W-1:0]] <= s_axis_afifo_tdata;
        if (rd_issue) mem_q <= mem[rd_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth         <= '0;
            wr_ptr        <= '0;
            rd_addr       <= '0;
            stored_count  <= '0;
            loop_cnt      <= '0;
            loop_mode     <= 1'b0;
            issue_done    <= 1'b1;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
            sk_valid      <= 1'b0;
            sk_last       <= 1'b0;
            sk_data       <= '0;
        end else begin
            if (cmd_write) begin
                depth        <= ((bram_depth == '0) || (bram_depth > CAPACITY)) ? CAPACITY : bram_depth;
                wr_ptr       <= '0;
                stored_count <= '0;
            end
            // stored_count follows every accepted beat, so a stop leaves it correct.
            if (wr_fire) begin
                wr_ptr       <= wr_ptr + ONE;
                stored_count <= wr_ptr + ONE;
            end

            if (cmd_read) begin
                rd_addr    <= '0;
                issue_done <= 1'b0;
                loop_mode  <= bram_loop;
                loop_cnt   <= '0;
            end else if (rd_issue) begin
                if (rd_is_last) begin
                    rd_addr    <= '0;
                    issue_done <= !loop_mode;
                end else begin
                    rd_addr <= rd_addr + ONE;
                end
            end

            if (rd_pop && out_last && (loop_cnt != CNT_MAX))
                loop_cnt <= loop_cnt + CNT_W'(1);

            if (rd_flush) begin
                inflight  <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                sk_valid  <= 1'b0;
            end else begin
                inflight      <= rd_issue;
                inflight_last <= rd_is_last;
                if (rd_pop) begin
                    if (sk_valid) begin
                        out_data <= sk_data;
                        out_last <= sk_last;
                        sk_valid <= inflight;
                        sk_data  <= mem_q;
                        sk_last  <= inflight_last;
                    end else begin
                        out_valid <= inflight;
                        out_data  <= mem_q;
                        out_last  <= inflight_last;
                    end
                end else if (inflight) begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= mem_q;
                        out_last  <= inflight_last;
                    end else begin
                        sk_valid <= 1'b1;
                        sk_data  <= mem_q;
                        sk_last  <= inflight_last;
                    end
                end
            end

            if (cmd_reset) begin
                stored_count <= '0;
                loop_cnt     <= '0;
                out_data     <= '0;
            end
        end
    end

endmodule

// File: doc/bram_stream_buffer.md
Name: bram_stream_buffer

Overview:
Parametrised capture/replay buffer for the AXI-Stream datapath between the MM2S async FIFO and the next processing stage. It writes a burst of up to 2^ADDR_W beats into inferred BRAM, then replays the stored frame to the downstream stream, either once or looped. Single clock domain. Control is by a command/opcode interface with a 2-bit status readback.

Parameters:
DATA_W, 128, stream data width in bits
ADDR_W, 10, BRAM address width; capacity = 2^ADDR_W beats
CNT_W, 16, width of the loop-pass counter

Ports:
clk  in  1  clock for all logic
rst  in  1  synchronous active-high reset
bram_status  out  2  00 RST, 01 WAITING, 10 WRITING, 11 READING
bram_en  in  1  command strobe; opcode sampled when high
bram_opts  in  2  00 reset, 01 write, 10 read, 11 stop
bram_depth  in  ADDR_W+1  requested write depth in beats
bram_loop  in  1  replay mode; sampled with the read command
stored_count  out  ADDR_W+1  beats currently held
loop_cnt  out  CNT_W  completed replay passes since the last read command
s_axis_afifo_tdata  in  DATA_W  input stream data
s_axis_afifo_tvalid  in  1  input valid
s_axis_afifo_tready  out  1  input ready
s_axis_afifo_tlast  in  1  input last
m_axis_bram_array_tdata  out  DATA_W  output stream data
m_axis_bram_array_tvalid  out  1  output valid
m_axis_bram_array_tready  in  1  output ready
m_axis_bram_array_tlast  out  1  output last

Behaviour:
- Reset is synchronous, active-high, with clk and rst as the port names. While rst is high: state RST, status 00. All stream valid, ready and last outputs are 0. tdata is 0, stored_count is 0, loop_cnt is 0. On the first clock after rst is released, the state becomes WAITING.
- RST state always moves to WAITING on the next clock.
- A command is accepted on a clock where bram_en=1.
  - Opcode 00 in any state: next state is RST. Stored contents are discarded, and stored_count and loop_cnt are cleared. Any in-flight stream transfer is abandoned.
  - Opcode 11 in WRITING or READING: next state is WAITING. Opcode 11 in WAITING does nothing.
  - Opcodes 01 and 10 are accepted only in WAITING. In other states they are ignored.
- WRITE (WAITING to WRITING):
  - Latch depth D = bram_depth. If D is 0 or greater than 2^ADDR_W, D = 2^ADDR_W.
  - Clear wr_ptr and stored_count.
  - s_axis_afifo_tready is 1 from the first WRITING cycle while wr_ptr < D.
  - Each beat with tvalid and tready writes mem[wr_ptr] and increments wr_ptr.
  - The write ends after the beat with wr_ptr = D-1, or after a beat with tlast=1, whichever comes first. On that cycle tready drops to 0 and the next state is WAITING, with stored_count = beats accepted.
  - A stop during WRITING keeps all beats accepted so far; stored_count = wr_ptr. A beat handshaken on the same cycle as the stop is counted.
  - A tlast that arrives before D beats is legal: the frame is short.
- READ (WAITING to READING):
  - Only legal if stored_count > 0. If stored_count = 0 the command is ignored and the state stays WAITING.
  - Latch bram_loop. Clear loop_cnt. Read from address 0.
  - The BRAM has 1-cycle read latency. An output register plus a skid stage provides full throughput.
  - First tvalid asserts no later than 3 clocks after the command cycle.
  - With tready held at 1, throughput is 1 beat per clock with no bubbles, including across loop wrap.
  - AXI rules: once tvalid=1, tdata and tlast stay stable until the handshake.
  - tlast=1 on beat stored_count-1 of every pass.
  - On the handshake of a tlast beat, loop_cnt increments, saturating at all-ones.
  - If loop=0, the next state is WAITING after the tlast handshake, with tvalid=0 on the following cycle.
  - If loop=1, the address wraps to 0 and replay continues until a stop or reset.
- Stop during READING aborts: tvalid and tlast go to 0 on the next clock, even mid-frame and without tlast. This is the accepted behaviour.
- Stored data survives WAITING→READING→WAITING, so repeated reads replay the same frame. Only a reset or a new write changes the contents.
- s_axis_afifo_tready is 0 outside WRITING. m_axis_bram_array_tvalid is 0 outside READING.
- Simultaneous events:
  - rst wins over any command.
  - A reset opcode wins over stream activity on the same clock.
  - A tlast beat and a stop on the same clock: the beat is stored.

Test Plan:
- rst for 2 cycles, then released → status 00 during rst, 01 on the next clock; all valid/ready/last outputs 0; stored_count=0.
- Write D=8 with 8 beats of data 0..7, tvalid always 1 → tready high for exactly 8 handshakes; status returns to 01; stored_count=8. Read with loop=0 and tready=1 → 8 back-to-back beats of data 0..7; tlast only on data 7; loop_cnt=1; status 01.
- Write D=16, then send 5 beats with tlast on beat 4 → stored_count=5. Read with tready toggling 1/0 every cycle → data 0..4 with stable tdata while stalled; tlast on beat 4.
- Read with loop=1 on stored_count=3 and tready=1 → sequence 0,1,2,0,1,2,0 with no gaps; loop_cnt=2 after the second tlast. Stop → tvalid 0 on the next clock; status 01.
- Write with D=0 on ADDR_W=4 → exactly 16 beats accepted, then tready=0. Read issued with stored_count=0 after a reset opcode → ignored; status stays 01.
- Reset opcode mid-write (after 3 beats) and mid-read → status 00 on the next clock; tready and tvalid 0; stored_count=0; then WAITING.
